// File: rtl/conv_operand_mem_if.sv
// Host/engine-facing signal bundle for conv_operand_mem; the readback pair is present
// only when CONV_OPERAND_MEM_RDBACK_EN is defined.
interface conv_operand_mem_if #(
   parameter int DW  = 8,
   parameter int DIM = 4,
   parameter int K   = 3,
   parameter int NCH = 2,
   parameter int RW  = 8
);
   localparam int OD   = DIM - K + 1;
   localparam int NRES = OD * OD;
   localparam int NE   = (DIM * DIM > K * K) ? DIM * DIM : K * K;
   localparam int AW   = (NE > 1) ? $clog2(NE) : 1;
   localparam int RA   = (NCH * NRES > 1) ? $clog2(NCH * NRES) : 1;

   logic                     cmd_clear;
   logic                     wr_en;
   logic                     wr_sel;
   logic [AW-1:0]            wr_addr;
   logic [DW-1:0]            wr_data;
   logic                     load_done;
   logic [DIM*DIM*DW-1:0]    data_bus;
   logic [K*K*DW-1:0]        filter_bus;
   logic                     mem_ready;
   logic                     res_valid;
   logic                     res_ready;
   logic [NCH*NRES*RW-1:0]   res_in;
   logic [NCH*NRES*RW-1:0]   res_bus;
   logic [2:0]               ms;
   logic                     wr_err;
`ifdef CONV_OPERAND_MEM_RDBACK_EN
   logic [RA-1:0]            rd_addr;
   logic [RW-1:0]            rd_data;
`endif

   modport master (
      output cmd_clear, wr_en, wr_sel, wr_addr, wr_data, load_done, res_valid, res_in,
`ifdef CONV_OPERAND_MEM_RDBACK_EN
      output rd_addr,
      input  rd_data,
`endif
      input  data_bus, filter_bus, mem_ready, res_ready, res_bus, ms, wr_err
   );

   modport slave (
      input  cmd_clear, wr_en, wr_sel, wr_addr, wr_data, load_done, res_valid, res_in,
`ifdef CONV_OPERAND_MEM_RDBACK_EN
      input  rd_addr,
      output rd_data,
`endif
      output data_bus, filter_bus, mem_ready, res_ready, res_bus, ms, wr_err
   );
endinterface

// File: rtl/conv_operand_mem.sv
// Operand/result store for the convolution engine: serial host load, flat operand buses,
// single valid/ready result capture per run. Optional readback: CONV_OPERAND_MEM_RDBACK_EN.
module conv_operand_mem #(
   parameter int DW  = 8,
   parameter int DIM = 4,
   parameter int K   = 3,
   parameter int NCH = 2,
   parameter int RW  = 8
) (
   input logic               clk,
   input logic               rst,
   conv_operand_mem_if.slave bus
);
   localparam int OD   = DIM - K + 1;
   localparam int NRES = OD * OD;
   localparam int ND   = DIM * DIM;
   localparam int NF   = K * K;
   localparam int NR   = NCH * NRES;

   localparam logic [2:0] S_IDLE  = 3'b000;
   localparam logic [2:0] S_LOAD  = 3'b011;
   localparam logic [2:0] S_ARMED = 3'b001;
   localparam logic [2:0] S_DONE  = 3'b010;

   logic [2:0]         state;
   logic [ND*DW-1:0]   data_q;
   logic [NF*DW-1:0]   filt_q;
   logic [NR*RW-1:0]   res_q;
   logic               mem_rdy_q;
   logic               res_rdy_q;
   logic               err_q;

   logic [31:0]        waddr;
   logic               legal;
   logic               wr_ok;
   logic               wr_bad;

   always_comb begin
      waddr  = 32'(bus.wr_addr);
      legal  = bus.wr_sel ? (waddr < 32'(NF)) : (waddr < 32'(ND));
      wr_ok  = bus.wr_en && legal && (state == S_IDLE || state == S_LOAD);
      wr_bad = bus.wr_en && !wr_ok;
   end

   always_ff @(posedge clk) begin
      if (rst || bus.cmd_clear) begin
         state     <= S_IDLE;
         data_q    <= '0;
         filt_q    <= '0;
         res_q     <= '0;
         mem_rdy_q <= 1'b0;
         res_rdy_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         // Element decode by loop keeps every select in range even for illegal addresses.
         if (wr_ok) begin
            for (int unsigned i = 0; i < ND; i++)
               if (!bus.wr_sel && waddr == i) data_q[i*DW +: DW] <= bus.wr_data;
            for (int unsigned i = 0; i < NF; i++)
               if (bus.wr_sel && waddr == i) filt_q[i*DW +: DW] <= bus.wr_data;
         end
         if (wr_bad) err_q <= 1'b1;
         case (state)
            S_IDLE:  if (wr_ok) state <= S_LOAD;
            S_LOAD:
               if (bus.load_done) begin
                  state     <= S_ARMED;
                  mem_rdy_q <= 1'b1;
                  res_rdy_q <= 1'b1;
               end
            S_ARMED:
               if (bus.res_valid && res_rdy_q) begin
                  res_q     <= bus.res_in;
                  state     <= S_DONE;
                  mem_rdy_q <= 1'b0;
                  res_rdy_q <= 1'b0;
               end
            default: ;
         endcase
      end
   end

   assign bus.data_bus   = data_q;
   assign bus.filter_bus = filt_q;
   assign bus.res_bus    = res_q;
   assign bus.mem_ready  = mem_rdy_q;
   assign bus.res_ready  = res_rdy_q;
   assign bus.ms         = state;
   assign bus.wr_err     = err_q;

`ifdef CONV_OPERAND_MEM_RDBACK_EN
   logic [RW-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (rst || bus.cmd_clear) begin
         rd_q <= '0;
      end else begin
         rd_q <= '0;
         for (int unsigned i = 0; i < NR; i++)
            if (32'(bus.rd_addr) == i) rd_q <= res_q[i*RW +: RW];
      end
   end

   assign bus.rd_data = rd_q;
`endif
endmodule

// File: tb/tb_conv_operand_mem.sv
// Scoreboard bench for conv_operand_mem: array-based reference model, expected snapshots
// queued per cycle and checked by an independent monitor on the falling edge.
module tb_conv_operand_mem;
   localparam int DW   = 8;
   localparam int DIM  = 4;
   localparam int K    = 3;
   localparam int NCH  = 2;
   localparam int RW   = 8;
   localparam int ND   = DIM * DIM;
   localparam int NF   = K * K;
   localparam int NRES = (DIM - K + 1) * (DIM - K + 1);
   localparam int NR   = NCH * NRES;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   conv_operand_mem_if #(.DW(DW), .DIM(DIM), .K(K), .NCH(NCH), .RW(RW)) bus ();

   conv_operand_mem #(.DW(DW), .DIM(DIM), .K(K), .NCH(NCH), .RW(RW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [ND*DW-1:0] d;
      logic [NF*DW-1:0] f;
      logic [NR*RW-1:0] r;
      logic [2:0]       ms;
      logic             mr;
      logic             rr;
      logic             err;
      logic [RW-1:0]    rd;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   int unsigned m_data[ND];
   int unsigned m_filt[NF];
   int unsigned m_res[NR];
   string       ph = "IDLE";
   bit          m_err = 1'b0;
   int unsigned m_rd = 0;

   function automatic void chk(string n, logic [255:0] a, logic [255:0] x);
      tests++;
      if (a !== x) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, a, x);
      end
   endfunction

   function automatic exp_t snap();
      exp_t e;
      for (int i = 0; i < ND; i++) e.d[i*DW +: DW] = DW'(m_data[i]);
      for (int i = 0; i < NF; i++) e.f[i*DW +: DW] = DW'(m_filt[i]);
      for (int i = 0; i < NR; i++) e.r[i*RW +: RW] = RW'(m_res[i]);
      case (ph)
         "LOAD":  e.ms = 3'b011;
         "ARMED": e.ms = 3'b001;
         "DONE":  e.ms = 3'b010;
         default: e.ms = 3'b000;
      endcase
      e.mr  = (ph == "ARMED");
      e.rr  = (ph == "ARMED");
      e.err = m_err;
      e.rd  = RW'(m_rd);
      return e;
   endfunction

   task automatic cycle(input bit r, input bit clr, input bit we, input bit sel, input int addr,
                        input int wd, input bit ld, input bit rv, input logic [NR*RW-1:0] rin,
                        input int ra);
      string       nxt;
      int unsigned rd_next;
      @(negedge clk);
      #1;
      rst           = r;
      bus.cmd_clear = clr;
      bus.wr_en     = we;
      bus.wr_sel    = sel;
      bus.wr_addr   = 4'(addr);
      bus.wr_data   = 8'(wd);
      bus.load_done = ld;
      bus.res_valid = rv;
      bus.res_in    = rin;
`ifdef CONV_OPERAND_MEM_RDBACK_EN
      bus.rd_addr   = 3'(ra);
`endif
      rd_next = (ra < NR) ? m_res[ra] : 0;
      if (r || clr) begin
         foreach (m_data[i]) m_data[i] = 0;
         foreach (m_filt[i]) m_filt[i] = 0;
         foreach (m_res[i]) m_res[i] = 0;
         ph    = "IDLE";
         m_err = 1'b0;
         m_rd  = 0;
      end else begin
         nxt  = ph;
         m_rd = rd_next;
         if (we) begin
            if ((ph == "IDLE" || ph == "LOAD") && addr < (sel ? NF : ND)) begin
               if (sel) m_filt[addr] = wd;
               else     m_data[addr] = wd;
               if (ph == "IDLE") nxt = "LOAD";
            end else begin
               m_err = 1'b1;
            end
         end
         if (ph == "LOAD" && ld) nxt = "ARMED";
         if (ph == "ARMED" && rv) begin
            for (int e = 0; e < NR; e++) m_res[e] = rin[e*RW +: RW];
            nxt = "DONE";
         end
         ph = nxt;
      end
      q.push_back(snap());
   endtask

   task automatic idle(input int ra);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, '0, ra);
   endtask

   task automatic wr(input bit sel, input int addr, input int wd);
      cycle(0, 0, 1, sel, addr, wd, 0, 0, '0, 0);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("data_bus", bus.data_bus, e.d);
            chk("filter_bus", bus.filter_bus, e.f);
            chk("res_bus", bus.res_bus, e.r);
            chk("ms", bus.ms, e.ms);
            chk("mem_ready", bus.mem_ready, e.mr);
            chk("res_ready", bus.res_ready, e.rr);
            chk("wr_err", bus.wr_err, e.err);
`ifdef CONV_OPERAND_MEM_RDBACK_EN
            chk("rd_data", bus.rd_data, e.rd);
`endif
         end
      end
   end

   initial begin
      int unsigned vals[ND];
      bus.cmd_clear = 0; bus.wr_en = 0; bus.wr_sel = 0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.load_done = 0; bus.res_valid = 0; bus.res_in = '0;
`ifdef CONV_OPERAND_MEM_RDBACK_EN
      bus.rd_addr = '0;
`endif
      cycle(1, 0, 0, 0, 0, 0, 0, 0, '0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, '0, 0);

      // load_done in IDLE is ignored; then full directed load
      cycle(0, 0, 0, 0, 0, 0, 1, 0, '0, 0);
      foreach (vals[i]) vals[i] = $urandom_range(0, 255);
      vals[0]  = 41;
      vals[15] = 235;
      for (int i = 0; i < ND; i++) wr(0, i, int'(vals[i]));
      for (int i = 0; i < NF; i++) wr(1, i, (i == 0) ? 41 : (i == NF - 1) ? 82 : int'($urandom_range(0, 255)));
      wr(1, 9, 8'hFF);
      wr(0, 3, 8'h5A);
      wr(0, 3, 8'hA5);
      cycle(0, 0, 1, 0, 7, 8'h77, 1, 0, '0, 0);
      idle(0);
      wr(0, 1, 8'h11);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 64'h0807060504030201, 5);
      idle(5);
      idle(8);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, {$urandom(), $urandom()}, 0);
      wr(1, 2, 8'h33);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, '0, 0);

      // second run: clear and res_valid together while ARMED
      wr(1, 4, 8'hC3);
      wr(0, 0, 8'h9);
      cycle(0, 0, 0, 0, 0, 0, 1, 0, '0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0, 1, {$urandom(), $urandom()}, 2);
      idle(0);

      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 2),
               ($urandom_range(0, 99) < 45), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
               ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 15),
               {$urandom(), $urandom()}, int'($urandom_range(0, 7)));
      end

      repeat (3) @(negedge clk);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
